// File: rtl/port_drain_reader.sv
// Round-robin consumer for the switch output ports: issues rd_en strobes, captures
// each word into a small output FIFO and streams it out tagged with its source port.
module port_drain_reader #(
  parameter int unsigned NPORTS    = 4,
  parameter int unsigned LANE_W    = 16,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NPORTS-1:0]           port_mask,
  input  logic [NPORTS*LANE_W-1:0]    data_out,
  input  logic [NPORTS*LANE_W-1:0]    addr_out,
  input  logic [NPORTS-1:0]           data_rdy,
  output logic [NPORTS-1:0]           rd_en,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANE_W-1:0]           m_data,
  output logic [LANE_W-1:0]           m_addr,
  output logic [$clog2(NPORTS)-1:0]   m_port,
  output logic [$clog2(OUT_DEPTH):0]  fifo_count,
  output logic [NPORTS*CNT_W-1:0]     word_cnt
);

  localparam int unsigned PW = $clog2(NPORTS);
  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC   = CW'(OUT_DEPTH);
  localparam logic [PW-1:0] LastInit = PW'(NPORTS - 1);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  typedef struct packed {
    logic [LANE_W-1:0] data;
    logic [LANE_W-1:0] addr;
    logic [PW-1:0]     port;
  } entry_t;

  state_e            state_q, state_d;
  logic [PW-1:0]     sel_q, sel_d;
  logic [PW-1:0]     last_q, last_d;
  logic [PW-1:0]     grant, cand;
  logic              grant_found;
  logic [NPORTS-1:0] eligible;
  logic              push, pop;

  logic [LANE_W-1:0] data_lane [NPORTS];
  logic [LANE_W-1:0] addr_lane [NPORTS];

  entry_t            mem_q [OUT_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic [CNT_W-1:0]  cnt_q [NPORTS];

  for (genvar i = 0; i < NPORTS; i++) begin : g_lane
    assign data_lane[i]                  = data_out[i*LANE_W +: LANE_W];
    assign addr_lane[i]                  = addr_out[i*LANE_W +: LANE_W];
    assign word_cnt[i*CNT_W +: CNT_W]    = cnt_q[i];
  end

  // Scan starts one past the last port that actually delivered a word.
  always_comb begin
    grant       = '0;
    cand        = '0;
    grant_found = 1'b0;
    eligible    = data_rdy & port_mask;
    for (int k = 1; k <= int'(NPORTS); k++) begin
      cand = PW'((int'(last_q) + k) % int'(NPORTS));
      if (!grant_found && eligible[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && grant_found && (count_q < DepthC)) begin
          sel_d   = grant;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StIdle;
        if (data_rdy[sel_q]) begin
          push   = 1'b1;
          last_d = sel_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobe comes from registered state only.
  always_comb begin
    rd_en = '0;
    if (state_q == StRead) rd_en[sel_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= LastInit;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign m_valid    = (count_q != '0);
  assign pop        = m_valid & m_ready;
  assign m_data     = mem_q[rptr_q].data;
  assign m_addr     = mem_q[rptr_q].addr;
  assign m_port     = mem_q[rptr_q].port;
  assign fifo_count = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= '{data: data_lane[sel_q], addr: addr_lane[sel_q], port: sel_q};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NPORTS); i++) cnt_q[i] <= '0;
    end else if (push && (cnt_q[sel_q] != '1)) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
    end
  end

endmodule

// File: tb/tb_port_drain_reader.sv
// Bench for port_drain_reader: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_port_drain_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  port_mask;
  logic [63:0] data_out;
  logic [63:0] addr_out;
  logic [3:0]  data_rdy;
  logic [3:0]  rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [15:0] m_addr;
  logic [1:0]  m_port;
  logic [2:0]  fifo_count;
  logic [63:0] word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  port_drain_reader dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .port_mask  (port_mask),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .data_rdy   (data_rdy),
    .rd_en      (rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_addr     (m_addr),
    .m_port     (m_port),
    .fifo_count (fifo_count),
    .word_cnt   (word_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    data_rdy = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Fixed lane contents for the directed part
  logic [15:0] fix_d [4] = '{16'h0F0F, 16'h1111, 16'hA5A5, 16'h3333};
  logic [15:0] fix_a [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0033};

  typedef struct {
    logic [3:0]  rdy;
    logic [3:0]  mask;
    logic        en;
    logic [3:0]  exp_rd;
    logic        exp_valid;
    logic [1:0]  exp_port;
    logic [15:0] exp_data;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  // Reference model state
  typedef struct packed {
    logic [15:0] d;
    logic [15:0] a;
    logic [1:0]  p;
  } word_t;

  word_t q[$];
  bit    mdl_busy;
  int    mdl_sel;
  int    mdl_last;
  int    mdl_cnt [4];

  task automatic model_step();
    int    sz;
    bit    found;
    word_t w;
    sz = q.size();
    if (sz != 0 && m_ready) w = q.pop_front();
    if (mdl_busy) begin
      mdl_busy = 0;
      if (data_rdy[mdl_sel]) begin
        w.d = data_out[mdl_sel*16 +: 16];
        w.a = addr_out[mdl_sel*16 +: 16];
        w.p = 2'(mdl_sel);
        q.push_back(w);
        if (mdl_cnt[mdl_sel] < 65535) mdl_cnt[mdl_sel]++;
        mdl_last = mdl_sel;
      end
    end else if (enable && sz < 4) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && data_rdy[(mdl_last + k) % 4] && port_mask[(mdl_last + k) % 4]) begin
          found    = 1;
          mdl_sel  = (mdl_last + k) % 4;
          mdl_busy = 1;
        end
      end
    end
  endtask

  task automatic randomize_inputs();
    data_rdy  = 4'($urandom_range(0, 15));
    port_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
    enable    = ($urandom_range(0, 9) != 0);
    m_ready   = 1'($urandom_range(0, 1));
    data_out  = {$urandom, $urandom};
    addr_out  = {$urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  exp_rd;
    logic [63:0] exp_cnt;
    bit          resumed;

    vecs[0] = '{4'b0100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hA5A5, 16'h0012};
    vecs[1] = '{4'b1111, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h1111, 16'h0011};
    vecs[2] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000, 16'h0000};
    vecs[3] = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h3333, 16'h0033};
    vecs[4] = '{4'b0001, 4'b1110, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000, 16'h0000};
    vecs[5] = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h1111, 16'h0011};
    vecs[6] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0F0F, 16'h0010};

    enable    = 1'b1;
    port_mask = 4'hF;
    data_rdy  = '0;
    m_ready   = 1'b0;
    data_out  = {fix_d[3], fix_d[2], fix_d[1], fix_d[0]};
    addr_out  = {fix_a[3], fix_a[2], fix_a[1], fix_a[0]};
    reset     = 1'b0;
    #1;
    check("reset values", {rd_en, m_valid, fifo_count, m_data, m_addr, m_port, word_cnt}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle with nothing presented
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle c%0d", c), {rd_en, m_valid, fifo_count}, '0);
    end

    // Table: single grant from fresh reset, then capture
    for (int v = 0; v < 7; v++) begin
      do_reset();
      data_rdy  = vecs[v].rdy;
      port_mask = vecs[v].mask;
      enable    = vecs[v].en;
      m_ready   = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rd_en", v), rd_en, vecs[v].exp_rd);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pulse", v), rd_en, '0);
      check($sformatf("vec%0d word", v), {m_valid, m_port, m_data, m_addr},
            {vecs[v].exp_valid, vecs[v].exp_port, vecs[v].exp_data, vecs[v].exp_addr});
      check($sformatf("vec%0d word_cnt", v), word_cnt,
            vecs[v].exp_valid ? (64'd1 << (vecs[v].exp_port * 16)) : 64'd0);
    end
    enable    = 1'b1;
    port_mask = 4'hF;

    // Round robin with everything ready
    do_reset();
    data_rdy = 4'hF;
    m_ready  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_rd = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
      check($sformatf("rr k%0d", k), rd_en, exp_rd);
    end

    // Backpressure: fill, stall, then drain in order
    do_reset();
    data_rdy = 4'hF;
    m_ready  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("bp full", fifo_count, 3'd4);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp stall c%0d", c), {rd_en, fifo_count}, {4'b0000, 3'd4});
    end
    m_ready = 1'b1;
    resumed = 0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp drain %0d", j), {m_valid, m_port, m_data, m_addr},
            {1'b1, 2'(j), fix_d[j], fix_a[j]});
      @(posedge clk);
      #1;
      if (rd_en != '0) resumed = 1;
    end
    for (int c = 0; c < 6 && !resumed; c++) begin
      @(posedge clk);
      #1;
      if (rd_en != '0) resumed = 1;
    end
    check("bp resume", resumed, 1'b1);

    // Withdrawn data during READ leaves last unchanged
    do_reset();
    m_ready  = 1'b0;
    data_rdy = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    data_rdy = 4'b0010;
    @(posedge clk);
    #1;
    check("wd grant1", rd_en, 4'b0010);
    data_rdy = 4'b0000;
    @(posedge clk);
    #1;
    check("wd no push", {fifo_count, word_cnt}, {3'd1, 64'd1});
    data_rdy = 4'b1111;
    @(posedge clk);
    #1;
    check("wd last kept", rd_en, 4'b0010);

    // Masked port never read
    do_reset();
    port_mask = 4'b1110;
    data_rdy  = 4'hF;
    m_ready   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("mask c%0d", c), rd_en[0], 1'b0);
    end
    port_mask = 4'hF;

    // Reset during READ clears everything
    do_reset();
    m_ready  = 1'b0;
    data_rdy = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    data_rdy = 4'hF;
    @(posedge clk);
    #1;
    check("rst pre read", {rd_en, fifo_count}, {4'b0010, 3'd1});
    reset = 1'b0;
    #1;
    check("rst mid read", {rd_en, m_valid, fifo_count, m_data, m_addr, m_port, word_cnt}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized run against the reference model
    do_reset();
    q.delete();
    mdl_busy = 0;
    mdl_sel  = 0;
    mdl_last = 3;
    for (int i = 0; i < 4; i++) mdl_cnt[i] = 0;
    randomize_inputs();
    for (int c = 0; c < 1500; c++) begin
      model_step();
      @(posedge clk);
      #1;
      exp_rd  = mdl_busy ? (4'b0001 << mdl_sel) : 4'b0000;
      exp_cnt = {16'(mdl_cnt[3]), 16'(mdl_cnt[2]), 16'(mdl_cnt[1]), 16'(mdl_cnt[0])};
      check($sformatf("rand ctl c%0d", c), {rd_en, m_valid, fifo_count, word_cnt},
            {exp_rd, q.size() != 0, 3'(q.size()), exp_cnt});
      if (q.size() != 0)
        check($sformatf("rand head c%0d", c), {m_data, m_addr, m_port}, {q[0].d, q[0].a, q[0].p});
      randomize_inputs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/port_drain_reader.md
Name: port_drain_reader

Overview:
- Consumer for the switch output side: watches the 4 per-port data_rdy flags and issues rd_en pulses.
- Captures each data_out/addr_out lane into an internal output FIFO.
- Presents captured words to bench or downstream logic over a valid/ready stream, tagged with the source port.
- Round-robin fairness across ports; software port mask; per-port word counters.

Parameters:
- NPORTS, 4, number of switch output ports.
- LANE_W, 16, bits per port lane in data_out/addr_out.
- OUT_DEPTH, 4, output FIFO depth (power of 2, >=2).
- CNT_W, 16, width of per-port word counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new reads are started.
- port_mask  in  NPORTS  1 = port eligible for reading.
- data_out  in  NPORTS*LANE_W  switch output data; lane i = [i*LANE_W +: LANE_W].
- addr_out  in  NPORTS*LANE_W  switch output address, same lane layout.
- data_rdy  in  NPORTS  port i has a word presented (show-ahead).
- rd_en  out  NPORTS  one-hot read strobe.
- m_valid  out  1  output word available.
- m_ready  in  1  downstream accepts.
- m_data  out  LANE_W  captured data.
- m_addr  out  LANE_W  captured address.
- m_port  out  clog2(NPORTS)  source port of the word.
- fifo_count  out  clog2(OUT_DEPTH)+1  output FIFO occupancy.
- word_cnt  out  NPORTS*CNT_W  per-port captured-word counters, saturating.

Behaviour:
- Reset (reset=0, async) values:
  - rd_en=0, m_valid=0, m_data=0, m_addr=0, m_port=0, fifo_count=0, word_cnt=0.
  - FSM=IDLE; round-robin pointer last=NPORTS-1.
  - Reset mid-read abandons the read; no capture.
- Protocol: a word on port i is consumed at a rising edge where rd_en[i]=1 and data_rdy[i]=1. data_out/addr_out lane i is valid in that same cycle and is captured at that edge.
- FSM states: IDLE, READ.
  - IDLE: compute eligible = data_rdy & port_mask. Start condition is enable=1, eligible!=0, and (fifo_count + 0) < OUT_DEPTH.
  - IDLE grant: choose the first eligible port scanning last+1, last+2, ... modulo NPORTS. Latch it as sel. Go to READ.
  - READ: rd_en = one-hot(sel), driven from registered state only, no combinational path from data_rdy.
  - READ, data_rdy[sel]=1 at the edge: push {data, addr, sel} into the FIFO, increment word_cnt[sel] (saturate at all-ones), set last=sel, go to IDLE.
  - READ, data_rdy[sel]=0 at the edge: no push, last unchanged, go to IDLE.
- Throughput: at most one word per 2 cycles. Latency from capture edge to m_valid=1 is 1 cycle when the FIFO was empty.
- FIFO space: a read is only started when at least one free entry exists. The single in-flight read is counted, so overflow is impossible.
- Output FIFO:
  - m_* reflect the head entry.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop keeps fifo_count unchanged, including when full.
  - Pop when empty is ignored.
  - Pointers wrap modulo OUT_DEPTH.
- enable or port_mask changes: affect only the next IDLE decision. A READ in progress completes.
- m_data/m_addr/m_port hold their values while m_valid=1 and m_ready=0.

Test Plan:
- Reset then idle: all data_rdy=0 -> rd_en stays 0, m_valid=0, fifo_count=0 for 20 cycles.
- Single port: data_rdy[2]=1 with lane2 data=0xA5A5, addr=0x0012, m_ready=1 -> rd_en=0b0100 for one cycle; next cycle m_valid=1, m_data=0xA5A5, m_addr=0x0012, m_port=2; word_cnt[2]=1.
- Round robin: all data_rdy=1 continuously, m_ready=1 -> read order 0,1,2,3,0,... with one rd_en pulse every 2 cycles.
- Backpressure: m_ready=0, all ports ready -> exactly 4 reads, then fifo_count=4 and rd_en stays 0. Raise m_ready -> 4 words drained in order and reads resume.
- Withdrawn data: data_rdy[1] drops in the READ cycle -> no push, word_cnt[1] unchanged, next grant still starts after port 0's position (last unchanged).
- Mask/enable/reset: port_mask=0b1110 -> port 0 never read. enable=0 -> no new reads. Assert reset during READ -> all outputs 0 immediately and FIFO empty.
